// File: rtl/y86_pkg.sv
// Shared Y86 icode constants, register-id sentinel and stack-pointer defaults.
package y86_pkg;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0]  RNONE       = 4'hF;
  localparam int          RSP_ID_DEF  = 4;
  localparam logic [63:0] RSP_INIT_DEF = 64'h0000_0000_0000_0200;

  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } ids_t;
endpackage

// File: rtl/decode_writeback_unit_if.sv
// Decode request/response and write-back bus of the decode/write-back unit.
interface decode_writeback_unit_if #(parameter int DATA_W = 64);
  logic              in_valid;
  logic [3:0]        in_code, ra, rb;
  logic              stall;
  logic              wb_valid;
  logic [3:0]        wb_code, wb_ra, wb_rb;
  logic              wb_cnd;
  logic [DATA_W-1:0] val_e, val_m;
  logic              out_valid;
  logic [DATA_W-1:0] val_a, val_b;
  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic              instr_err;

  modport master (
    output in_valid, in_code, ra, rb, stall,
    output wb_valid, wb_code, wb_ra, wb_rb, wb_cnd, val_e, val_m,
    input  out_valid, val_a, val_b, src_a, src_b, dst_e, dst_m, instr_err
  );
  modport slave (
    input  in_valid, in_code, ra, rb, stall,
    input  wb_valid, wb_code, wb_ra, wb_rb, wb_cnd, val_e, val_m,
    output out_valid, val_a, val_b, src_a, src_b, dst_e, dst_m, instr_err
  );
endinterface

// File: rtl/y86_regfile.sv
// Register file: 2 read / 2 write ports, same-cycle write bypass, M port wins.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter int                NREGS    = 15,
  parameter int                RSP_ID   = RSP_ID_DEF,
  parameter logic [DATA_W-1:0] RSP_INIT = DATA_W'(RSP_INIT_DEF)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        ra_id_i,
  input  logic [3:0]        rb_id_i,
  output logic [DATA_W-1:0] ra_data_o,
  output logic [DATA_W-1:0] rb_data_o,
  input  logic              we_e_i,
  input  logic [3:0]        we_id_i,
  input  logic [DATA_W-1:0] we_data_i,
  input  logic              wm_e_i,
  input  logic [3:0]        wm_id_i,
  input  logic [DATA_W-1:0] wm_data_i
);
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [3:0]        rd_id  [2];
  logic [DATA_W-1:0] rd_dat [2];
  logic              e_act, m_act;

  function automatic logic id_ok(input logic [3:0] id);
    return (id != RNONE) && (32'(id) < NREGS);
  endfunction

  assign e_act = we_e_i && id_ok(we_id_i);
  assign m_act = wm_e_i && id_ok(wm_id_i);
  assign rd_id[0] = ra_id_i;
  assign rd_id[1] = rb_id_i;
  assign ra_data_o = rd_dat[0];
  assign rb_data_o = rd_dat[1];

  // Later assignments take priority: M bypass over E bypass over storage.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_dat[p] = '0;
      for (int i = 0; i < NREGS; i++)
        if (id_ok(rd_id[p]) && rd_id[p] == 4'(i)) rd_dat[p] = regs_q[i];
      if (e_act && rd_id[p] == we_id_i) rd_dat[p] = we_data_i;
      if (m_act && rd_id[p] == wm_id_i) rd_dat[p] = wm_data_i;
    end
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (e_act && we_id_i == 4'(i)) regs_d[i] = we_data_i;
      if (m_act && wm_id_i == 4'(i)) regs_d[i] = wm_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= (i == RSP_ID) ? RSP_INIT : '0;
    end else begin
      regs_q <= regs_d;
    end
  end
endmodule

// File: rtl/decode_writeback_unit.sv
// Y86 decode stage with registered outputs plus write-back into the register file.
module decode_writeback_unit
  import y86_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter int                NREGS    = 15,
  parameter int                RSP_ID   = RSP_ID_DEF,
  parameter logic [DATA_W-1:0] RSP_INIT = DATA_W'(RSP_INIT_DEF)
) (
  input logic                    clock,
  input logic                    reset,
  decode_writeback_unit_if.slave bus
);
  localparam logic [3:0] RSP = 4'(RSP_ID);

  ids_t              dec_ids, wb_ids, ids_q, ids_d;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] val_a_q, val_a_d, val_b_q, val_b_d;
  logic              out_valid_q, out_valid_d, instr_err_q, instr_err_d;

  // cnd only gates dstE of rrmovq/cmovXX; decode always passes 1.
  function automatic ids_t ids_of(input logic [3:0] code, input logic [3:0] a,
                                  input logic [3:0] b, input logic cnd);
    ids_t r;
    r = '{RNONE, RNONE, RNONE, RNONE};
    case (code)
      IRRMOVQ: begin r.src_a = a; r.dst_e = cnd ? b : RNONE; end
      IIRMOVQ: r.dst_e = b;
      IRMMOVQ: begin r.src_a = a; r.src_b = b; end
      IMRMOVQ: begin r.src_b = b; r.dst_m = a; end
      IOPQ:    begin r.src_a = a; r.src_b = b; r.dst_e = b; end
      ICALL:   begin r.src_b = RSP; r.dst_e = RSP; end
      IRET:    begin r.src_a = RSP; r.src_b = RSP; r.dst_e = RSP; end
      IPUSHQ:  begin r.src_a = a; r.src_b = RSP; r.dst_e = RSP; end
      IPOPQ:   begin r.src_a = RSP; r.src_b = RSP; r.dst_e = RSP; r.dst_m = a; end
      default: ;
    endcase
    return r;
  endfunction

  assign dec_ids = ids_of(bus.in_code, bus.ra, bus.rb, 1'b1);
  assign wb_ids  = ids_of(bus.wb_code, bus.wb_ra, bus.wb_rb, bus.wb_cnd);

  y86_regfile #(
    .DATA_W(DATA_W), .NREGS(NREGS), .RSP_ID(RSP_ID), .RSP_INIT(RSP_INIT)
  ) u_rf (
    .clk_i    (clock),
    .rst_i    (reset),
    .ra_id_i  (dec_ids.src_a),
    .rb_id_i  (dec_ids.src_b),
    .ra_data_o(rd_a),
    .rb_data_o(rd_b),
    .we_e_i   (bus.wb_valid),
    .we_id_i  (wb_ids.dst_e),
    .we_data_i(bus.val_e),
    .wm_e_i   (bus.wb_valid),
    .wm_id_i  (wb_ids.dst_m),
    .wm_data_i(bus.val_m)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    instr_err_d = instr_err_q;
    ids_d       = ids_q;
    val_a_d     = val_a_q;
    val_b_d     = val_b_q;
    if (!bus.stall) begin
      out_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        instr_err_d = bus.in_code > IPOPQ;
        ids_d       = dec_ids;
        val_a_d     = rd_a;
        val_b_d     = rd_b;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      instr_err_q <= 1'b0;
      ids_q       <= '{RNONE, RNONE, RNONE, RNONE};
      val_a_q     <= '0;
      val_b_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      instr_err_q <= instr_err_d;
      ids_q       <= ids_d;
      val_a_q     <= val_a_d;
      val_b_q     <= val_b_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.instr_err = instr_err_q;
  assign bus.val_a     = val_a_q;
  assign bus.val_b     = val_b_q;
  assign bus.src_a     = ids_q.src_a;
  assign bus.src_b     = ids_q.src_b;
  assign bus.dst_e     = ids_q.dst_e;
  assign bus.dst_m     = ids_q.dst_m;
endmodule

// File: tb/tb_decode_writeback_unit.sv
// Directed bench for decode_writeback_unit: decode, bypass, cmov, popq, stall, reset.
module tb_decode_writeback_unit;
  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  decode_writeback_unit_if #(.DATA_W(64)) bus ();

  decode_writeback_unit #(
    .DATA_W(64), .NREGS(15), .RSP_ID(4), .RSP_INIT(64'h200)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dec(input logic v, input logic [3:0] code, input logic [3:0] a,
                     input logic [3:0] b);
    bus.in_valid = v; bus.in_code = code; bus.ra = a; bus.rb = b;
  endtask

  task automatic wb(input logic v, input logic [3:0] code, input logic [3:0] a,
                    input logic [3:0] b, input logic cnd, input logic [63:0] e,
                    input logic [63:0] m);
    bus.wb_valid = v; bus.wb_code = code; bus.wb_ra = a; bus.wb_rb = b;
    bus.wb_cnd = cnd; bus.val_e = e; bus.val_m = m;
  endtask

  // rmmovq reads ra into val_a and rb into val_b with no destinations.
  task automatic rd_regs(input logic [3:0] a, input logic [3:0] b,
                         input logic [63:0] ea, input logic [63:0] eb, input string tag);
    dec(1, 4'h4, a, b);
    wb(0, 4'h0, 4'hF, 4'hF, 0, 0, 0);
    tick();
    chk({tag, "_a"}, bus.val_a, ea);
    chk({tag, "_b"}, bus.val_b, eb);
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0;
    dec(0, 4'h0, 4'hF, 4'hF);
    wb(0, 4'h0, 4'hF, 4'hF, 0, 0, 0);
    tick();
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_instr_err", 64'(bus.instr_err), 64'd0);
    chk("rst_val_a", bus.val_a, 64'd0);
    chk("rst_val_b", bus.val_b, 64'd0);
    chk("rst_src_a", 64'(bus.src_a), 64'hF);
    chk("rst_dst_m", 64'(bus.dst_m), 64'hF);

    // ret accepted on the cycle reset deasserts
    reset = 1'b0;
    dec(1, 4'h9, 4'hF, 4'hF);
    tick();
    chk("ret_valid", 64'(bus.out_valid), 64'd1);
    chk("ret_val_a", bus.val_a, 64'h200);
    chk("ret_val_b", bus.val_b, 64'h200);
    chk("ret_src_a", 64'(bus.src_a), 64'd4);
    chk("ret_src_b", 64'(bus.src_b), 64'd4);
    chk("ret_dst_e", 64'(bus.dst_e), 64'd4);
    chk("ret_dst_m", 64'(bus.dst_m), 64'hF);

    // irmovq writes r2 while opq r2,r2 decodes in the same cycle
    dec(1, 4'h6, 4'h2, 4'h2);
    wb(1, 4'h3, 4'hF, 4'h2, 0, 64'h55, 64'h0);
    tick();
    chk("byp_val_a", bus.val_a, 64'h55);
    chk("byp_val_b", bus.val_b, 64'h55);
    chk("opq_dst_e", 64'(bus.dst_e), 64'd2);
    rd_regs(4'h2, 4'hF, 64'h55, 64'h0, "r2_stored");

    // cmov not taken, then taken; in_valid=0 clears out_valid
    dec(0, 4'h0, 4'hF, 4'hF);
    wb(1, 4'h2, 4'h1, 4'h3, 0, 64'h7, 64'h0);
    tick();
    chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    rd_regs(4'h3, 4'h1, 64'h0, 64'h0, "cmov_nt");
    dec(0, 4'h0, 4'hF, 4'hF);
    wb(1, 4'h2, 4'h1, 4'h3, 1, 64'h7, 64'h0);
    tick();
    rd_regs(4'h3, 4'h1, 64'h7, 64'h0, "cmov_t");

    // popq %rsp: val_m wins, including through the bypass
    dec(1, 4'h4, 4'h4, 4'hF);
    wb(1, 4'hB, 4'h4, 4'hF, 0, 64'h208, 64'hAA);
    tick();
    chk("popq_byp", bus.val_a, 64'hAA);
    rd_regs(4'h4, 4'h3, 64'hAA, 64'h7, "popq_rsp");

    // invalid write-back code writes nothing
    dec(0, 4'h0, 4'hF, 4'hF);
    wb(1, 4'hC, 4'h1, 4'h1, 1, 64'h99, 64'h99);
    tick();
    rd_regs(4'h1, 4'h3, 64'h0, 64'h7, "bad_wb");

    // mrmovq ids
    dec(1, 4'h5, 4'h6, 4'h2);
    tick();
    chk("mr_dst_m", 64'(bus.dst_m), 64'd6);
    chk("mr_src_b", 64'(bus.src_b), 64'd2);
    chk("mr_val_b", bus.val_b, 64'h55);

    // rmmovq then stall three cycles with changing inputs; wb continues
    rd_regs(4'h2, 4'h3, 64'h55, 64'h7, "pre_stall");
    bus.stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      dec(c != 1, 4'h6, 4'h4, 4'(c + 5));
      wb(c == 0, 4'h3, 4'hF, 4'h6, 0, 64'h66, 64'h0);
      tick();
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_val_a", bus.val_a, 64'h55);
      chk("stall_src_a", 64'(bus.src_a), 64'd2);
      chk("stall_dst_e", 64'(bus.dst_e), 64'hF);
    end
    bus.stall = 1'b0;
    rd_regs(4'h6, 4'h4, 64'h66, 64'hAA, "wb_in_stall");

    // illegal icode
    dec(1, 4'hD, 4'h2, 4'h3);
    tick();
    chk("err_flag", 64'(bus.instr_err), 64'd1);
    chk("err_valid", 64'(bus.out_valid), 64'd1);
    chk("err_src_a", 64'(bus.src_a), 64'hF);
    chk("err_dst_e", 64'(bus.dst_e), 64'hF);
    chk("err_val_a", bus.val_a, 64'd0);
    rd_regs(4'h2, 4'hF, 64'h55, 64'h0, "after_err");
    chk("err_clear", 64'(bus.instr_err), 64'd0);

    // reset wins over concurrent write-back and decode
    dec(0, 4'h0, 4'hF, 4'hF);
    wb(1, 4'h3, 4'hF, 4'h5, 0, 64'h5A, 64'h0);
    tick();
    rd_regs(4'h5, 4'h4, 64'h5A, 64'hAA, "r5_set");
    reset = 1'b1;
    dec(1, 4'h6, 4'h5, 4'h5);
    wb(1, 4'h3, 4'hF, 4'h7, 0, 64'h77, 64'h0);
    tick();
    chk("rst2_valid", 64'(bus.out_valid), 64'd0);
    chk("rst2_src_a", 64'(bus.src_a), 64'hF);
    reset = 1'b0;
    rd_regs(4'h5, 4'h7, 64'h0, 64'h0, "rst2_regs");
    rd_regs(4'h4, 4'h2, 64'h200, 64'h0, "rst2_rsp");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/decode_writeback_unit.md
DECODE_WRITEBACK_UNIT -- requirements
Module: decode_writeback_unit

Interface
REQ-001 Parameter DATA_W, default 64, register and operand width in bits.
REQ-002 Parameter NREGS, default 15, number of architectural registers (ids 0..NREGS-1; id 4'hF = none).
REQ-003 Parameter RSP_ID, default 4, register id used as stack pointer.
REQ-004 Parameter RSP_INIT, default 64'h0000_0000_0000_0200, reset value of register RSP_ID; all others reset to 0.
REQ-005 clock  input  1  single clock, all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  decode request present this cycle.
REQ-008 in_code  input  4  icode of instruction being decoded.
REQ-009 ra, rb  input  4 each  register specifier fields.
REQ-010 stall  input  1  hold decode output registers unchanged.
REQ-011 wb_valid  input  1  write-back request present this cycle.
REQ-012 wb_code  input  4  icode of retiring instruction.
REQ-013 wb_ra, wb_rb  input  4 each  register fields of retiring instruction.
REQ-014 wb_cnd  input  1  condition result of retiring instruction (cmovXX).
REQ-015 val_e, val_m  input  DATA_W each  execute and memory results to write back.
REQ-016 out_valid  output  1  decode outputs valid.
REQ-017 val_a, val_b  output  DATA_W each  operand values.
REQ-018 src_a, src_b, dst_e, dst_m  output  4 each  decoded register ids (4'hF = none).
REQ-019 instr_err  output  1  in_code > 4'hB on a valid decode.

Function
REQ-020 srcA SHALL be ra for icode 2,4,6,A; RSP_ID for 9,B; else 4'hF.
REQ-021 srcB SHALL be rb for icode 4,5,6; RSP_ID for 8,9,A,B; else 4'hF.
REQ-022 Decode dstE SHALL be rb for icode 2,3,6; RSP_ID for 8,9,A,B; else 4'hF; dstM SHALL be ra for 5,B; else 4'hF.
REQ-023 Write-back SHALL compute dstE/dstM from wb_code/wb_ra/wb_rb with REQ-022 rules, except icode 2 with wb_cnd=0 gives dstE=4'hF.
REQ-024 On a wb_valid cycle, val_e SHALL be written to dstE and val_m to dstM at the rising edge; id 4'hF or >= NREGS is not written.
REQ-025 When dstE == dstM (popq %rsp), val_m SHALL win.
REQ-026 Read of id 4'hF or >= NREGS SHALL return 0.
REQ-027 Reads SHALL bypass same-cycle write-back: a source equal to active dstM returns val_m, else equal to active dstE returns val_e, else register content.
REQ-028 Decode latency SHALL be 1 cycle: when in_valid=1 and stall=0, outputs register at next edge with out_valid=1.
REQ-029 in_valid=0 and stall=0 SHALL clear out_valid at next edge; other outputs are don't-care but held.
REQ-030 stall=1 SHALL hold all decode outputs including out_valid; write-back proceeds regardless of stall.
REQ-031 instr_err SHALL register 1 with out_valid for in_code 4'hC..4'hF; all ids then 4'hF and val_a=val_b=0.
REQ-032 Write-back with invalid wb_code SHALL write nothing.

Reset
REQ-033 reset=1 at an edge SHALL set all registers to 0 except RSP_ID=RSP_INIT, and clear out_valid, instr_err, val_a, val_b, and set src/dst outputs to 4'hF.
REQ-034 reset SHALL take priority over write-back and decode in the same cycle; no write occurs.
REQ-035 First decode SHALL be accepted on the cycle reset deasserts.

Structure
REQ-036 Icode constants (IHALT..IPOPQ), RNONE=4'hF and the stack-pointer default SHALL live in a shared package y86_pkg.
REQ-037 Register storage with 2 read/2 write ports and bypass SHALL be sub-module y86_regfile; decode id logic SHALL stay in this module.

Verification
REQ-038 Reset, then decode icode 9 (ret) -> next cycle val_a=val_b=64'h200, src_a=src_b=4, dst_e=4, out_valid=1.
REQ-039 wb icode 3 rb=2 val_e=64'h55 while decoding icode 6 ra=2 rb=2 in same cycle -> val_a=val_b=64'h55 (bypass).
REQ-040 wb icode 2 ra=1 rb=3 wb_cnd=0 val_e=7 -> register 3 unchanged; with wb_cnd=1 -> register 3 = 7.
REQ-041 wb icode B ra=4 val_e=64'h208 val_m=64'hAA -> register 4 = 64'hAA.
REQ-042 Decode icode 4 then stall=1 for 3 cycles with new inputs -> outputs frozen, out_valid stays 1; in_code 4'hD -> instr_err=1, ids 4'hF.
REQ-043 Write register 5, assert reset same cycle as another wb -> register 5 = 0, out_valid=0, no write.
